// File: rtl/nibble_serial_adder16.sv
// rtl/nibble_serial_adder16.sv - nibble-serial WIDTH-bit adder built around one 4-bit CLA slice
// Operands are latched, then one nibble per cycle passes through the shared slice, LSB first.

module adder_4bit (
  output logic [3:0] S,
  output logic       c_out,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       c_in
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  // Every carry is a flat function of g/p/c_in, so none of them ripples.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign S     = p ^ c[3:0];
  assign c_out = c[4];
endmodule

module nibble_serial_adder16 #(
  parameter int WIDTH = 16,
  parameter int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_q, state_d;
  logic [NIB-1:0][3:0]   a_q, a_d;
  logic [NIB-1:0][3:0]   b_q, b_d;
  logic [NIB-1:0][3:0]   sum_q, sum_d;
  logic                  carry_q, carry_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic                  cout_q, cout_d;
  logic                  ovf_q, ovf_d;

  logic [3:0]            slice_s;
  logic                  slice_c;

  // Slice inputs come only from registers, so its output is defined in every state.
  adder_4bit u_slice (
    .S     (slice_s),
    .c_out (slice_c),
    .A     (a_q[idx_q]),
    .B     (b_q[idx_q]),
    .c_in  (carry_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[idx_q] = slice_s;
        carry_d      = slice_c;
        if (idx_q == LAST_IDX) begin
          // The top nibble is being written now, so its MSB is the final sum MSB.
          cout_d  = slice_c;
          ovf_d   = (a_q[NIB-1][3] == b_q[NIB-1][3]) && (slice_s[3] != a_q[NIB-1][3]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = cout_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder16.sv
// tb/tb_nibble_serial_adder16.sv - scoreboard bench for nibble_serial_adder16
// Driver pushes expected results on acceptance; a monitor pops on every output handshake.

module tb_nibble_serial_adder16;
  localparam int W = 16;
  localparam int LAT = W / 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_accept = 0;
  int   n_hs = 0;
  bit   stall_en = 1'b0;
  bit   prev_valid = 1'b0;
  exp_t sb[$];

  nibble_serial_adder16 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, contents on each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
        else check("latency", cyc, sb[0].acc + LAT);
      end
      if (out_valid && out_ready) begin
        n_hs++;
        if (sb.size() == 0) begin
          check("handshake_without_accept", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sum", sum, e.s);
          check("c_out", c_out, e.c);
          check("overflow", overflow, e.v);
        end
      end
      prev_valid = out_valid;
    end
  end

  // Random output backpressure, driven away from the sampling edge.
  always @(posedge clk) begin
    if (stall_en) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input logic [W-1:0] es, input logic ec, input logic ev, input bit track);
    bit done;
    exp_t e;
    done = 1'b0;
    a = ta; b = tb_; c_in = tc; in_valid = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.s = es; e.c = ec; e.v = ev; e.acc = cyc + 1;
        @(posedge clk);
        if (track) begin
          sb.push_back(e);
          n_accept++;
        end
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 0, 1);
    #1;
    in_valid = 1'b0;
    // Scramble inputs after acceptance; the in-flight result must not change.
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
  endtask

  task automatic issue_model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    logic [W:0] full;
    logic       v;
    full = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
    v = (ta[W-1] == tb_[W-1]) && (full[W-1] != ta[W-1]);
    issue(ta, tb_, tc, full[W-1:0], full[W], v, 1'b1);
  endtask

  initial begin
    logic [W-1:0] cap_s;
    logic         cap_c, cap_v;
    bit           seen;

    // Reset state
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
    check("rst_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Abort an operation mid-BUSY with reset
    issue(16'hAAAA, 16'h5555, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("busy_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, hand-computed
    issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);
    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    issue(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1);
    issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    issue(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);

    // Backpressure: hold out_ready low in DONE while inputs toggle
    repeat (LAT + 3) @(posedge clk);
    #1 out_ready = 1'b0;
    issue(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) check("bp_valid_timeout", 0, 1);
    cap_s = sum; cap_c = c_out; cap_v = overflow;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom); in_valid = ~in_valid;
      @(negedge clk);
      check("bp_sum_stable", sum, cap_s);
      check("bp_flags_stable", {c_out, overflow}, {cap_c, cap_v});
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);

    // Random regression with random output stalls
    stall_en = 1'b1;
    for (int i = 0; i < 1000; i++)
      issue_model(W'($urandom), W'($urandom), 1'($urandom));
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    stall_en = 1'b0;
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);

    check("scoreboard_drained", sb.size(), 0);
    check("handshake_count", n_hs, n_accept);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
